// File: rtl/avmm_wide_data_pkg.sv
// rtl/avmm_wide_data_pkg.sv - shared constants and helpers for the wide data FIFO
// Purpose: CTRL/STATUS bit positions, word count and register offsets.
// Ports: none (package).
package avmm_wide_data_pkg;

    // CTRL register bits
    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_FLUSH  = 2;

    // STATUS register bits (level occupies the low bits)
    localparam int STATUS_EMPTY    = 16;
    localparam int STATUS_FULL     = 17;
    localparam int STATUS_OVERFLOW = 18;

    // Number of bus words that make up one wide entry
    function automatic int num_words(input int data_w, input int bus_w);
        return data_w / bus_w;
    endfunction

    // CTRL sits right after the shadow words, STATUS right after CTRL
    function automatic int ctrl_offset(input int n);
        return n;
    endfunction

    function automatic int status_offset(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_wide.sv
// rtl/sync_fifo_wide.sv - single-clock wide FIFO with flush and drop indication
// Purpose: DEPTH-entry FIFO of DATA_W-bit entries, head exposed combinationally.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : push request, push_data is the entry
//   pop          : pop request (ignored when empty)
//   flush        : empties the FIFO; overrides push and pop
//   head         : contents of the slot at the read pointer
//   full, empty  : occupancy flags
//   level        : occupancy, wr_ptr - rd_ptr
//   drop         : push request rejected because the FIFO was full with no pop
module sync_fifo_wide #(
    parameter  int DATA_W = 256,
    parameter  int DEPTH  = 4,
    localparam int LW     = $clog2(DEPTH) + 1,
    localparam int IW     = LW - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level,
    output logic              drop
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LW-1:0]     wr_ptr;
    logic [LW-1:0]     rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    // Pointers carry one extra bit so full and empty are distinguishable
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign push_ok = push && (!full || pop_ok);
    // Flush swallows pushes silently; they are not overflows
    assign drop    = push && !flush && !push_ok;

    assign head = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[IW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + LW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
        end
    end

endmodule

// File: rtl/avmm_wide_data_fifo.sv
// rtl/avmm_wide_data_fifo.sv - Avalon-MM shadow register with atomic commit into a wide FIFO
// Purpose: software assembles a DATA_W-bit entry from BUS_W-bit words and commits it
//          atomically into a FIFO drained by fabric logic over valid/ready.
// Ports:
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   avs_*                  : Avalon-MM slave, no waitrequest, read latency 1
//   out_data, out_valid    : FIFO head and non-empty flag
//   out_ready              : consumer accepts the head
//   out_level              : FIFO occupancy
module avmm_wide_data_fifo
    import avmm_wide_data_pkg::*;
#(
    parameter  int DATA_W      = 256,
    parameter  int BUS_W       = 32,
    parameter  int DEPTH       = 4,
    parameter  int AUTO_COMMIT = 0,
    localparam int N           = num_words(DATA_W, BUS_W),
    localparam int AW          = $clog2(N + 2),
    localparam int LW          = $clog2(DEPTH) + 1,
    localparam int BE_W        = BUS_W / 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [AW-1:0]     avs_address,
    input  logic              avs_write,
    input  logic [BUS_W-1:0]  avs_writedata,
    input  logic [BE_W-1:0]   avs_byteenable,
    input  logic              avs_read,
    output logic [BUS_W-1:0]  avs_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LW-1:0]     out_level
);

    localparam logic [AW-1:0] CTRL_ADDR   = AW'(ctrl_offset(N));
    localparam logic [AW-1:0] STATUS_ADDR = AW'(status_offset(N));
    localparam logic [AW-1:0] LAST_ADDR   = AW'(N - 1);

    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] shadow_merged;
    logic [DATA_W-1:0] shadow_next;
    logic              ctrl_wr;
    logic              status_wr;
    logic              commit;
    logic              flush;
    logic              overflow;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    logic [BUS_W-1:0]  rd_word;

    assign ctrl_wr   = avs_write && (avs_address == CTRL_ADDR);
    assign status_wr = avs_write && (avs_address == STATUS_ADDR);

    // Byte-lane merge of the current write into the shadow
    always_comb begin
        shadow_merged = shadow;
        for (int k = 0; k < N; k++) begin
            if (avs_write && (avs_address == AW'(k))) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (avs_byteenable[b]) begin
                        shadow_merged[k*BUS_W + b*8 +: 8] = avs_writedata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // CLEAR applies after the commit capture: the FIFO sees shadow_merged,
    // which on a CTRL write is just the untouched shadow.
    assign shadow_next = (ctrl_wr && avs_writedata[CTRL_CLEAR]) ? '0 : shadow_merged;

    assign commit = (ctrl_wr && avs_writedata[CTRL_COMMIT]) ||
                    ((AUTO_COMMIT != 0) && avs_write && (avs_address == LAST_ADDR));
    assign flush  = ctrl_wr && avs_writedata[CTRL_FLUSH];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            shadow <= '0;
        end else begin
            shadow <= shadow_next;
        end
    end

    sync_fifo_wide #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .push      (commit),
        .push_data (shadow_merged),
        .pop       (out_ready),
        .flush     (flush),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (out_level),
        .drop      (fifo_drop)
    );

    assign out_valid = !fifo_empty;

    // Sticky overflow; a clear and a drop cannot coincide since they
    // come from writes to different addresses.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overflow <= 1'b0;
        end else if (status_wr && avs_writedata[STATUS_OVERFLOW]) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end
    end

    // Read mux; CTRL and unmapped addresses return 0
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N; k++) begin
            if (avs_address == AW'(k)) begin
                rd_word = shadow[k*BUS_W +: BUS_W];
            end
        end
        if (avs_address == STATUS_ADDR) begin
            rd_word[LW-1:0]        = out_level;
            rd_word[STATUS_EMPTY]    = fifo_empty;
            rd_word[STATUS_FULL]     = fifo_full;
            rd_word[STATUS_OVERFLOW] = overflow;
        end
    end

    // Registered read data, held until the next read
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_avmm_wide_data_fifo.sv
// tb/tb_avmm_wide_data_fifo.sv - self-checking bench for avmm_wide_data_fifo
module tb_avmm_wide_data_fifo;

    logic         clk;
    logic         rst_n;
    logic [3:0]   address;
    logic         write;
    logic [31:0]  writedata;
    logic [3:0]   byteenable;
    logic         read;
    logic         out_ready;
    logic [31:0]  readdata0,  readdata1;
    logic [255:0] out_data0,  out_data1;
    logic         out_valid0, out_valid1;
    logic [2:0]   out_level0, out_level1;

    int n_assert = 0;
    int n_fail   = 0;

    // Two instances share all inputs: one manual-commit, one auto-commit
    avmm_wide_data_fifo #(.DATA_W(256), .BUS_W(32), .DEPTH(4), .AUTO_COMMIT(0)) dut0 (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(address), .avs_write(write),
        .avs_writedata(writedata), .avs_byteenable(byteenable), .avs_read(read),
        .avs_readdata(readdata0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_level(out_level0));

    avmm_wide_data_fifo #(.DATA_W(256), .BUS_W(32), .DEPTH(4), .AUTO_COMMIT(1)) dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(address), .avs_write(write),
        .avs_writedata(writedata), .avs_byteenable(byteenable), .avs_read(read),
        .avs_readdata(readdata1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_level(out_level1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: shadow as word array, each FIFO as an ordered list
    logic [31:0]  msh [8];
    logic [255:0] mq  [2][4];
    int           mcnt [2];
    bit           mov  [2];
    logic [31:0]  mrd  [2];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) msh[k] = '0;
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0;
            mov[i]  = 1'b0;
            mrd[i]  = '0;
        end
    endtask

    function automatic logic [31:0] read_value(input int i, input logic [3:0] a);
        logic [31:0] v;
        v = '0;
        if (a < 4'd8) begin
            v = msh[a];
        end else if (a == 4'd9) begin
            v[2:0] = 3'(mcnt[i]);
            v[16]  = (mcnt[i] == 0);
            v[17]  = (mcnt[i] == 4);
            v[18]  = mov[i];
        end
        return v;
    endfunction

    task automatic model_update();
        logic [31:0]  merged [8];
        logic [255:0] vec;
        bit           pop, push, flush;
        if (read) begin
            for (int i = 0; i < 2; i++) mrd[i] = read_value(i, address);
        end
        merged = msh;
        if (write && address < 4'd8) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) merged[address][b*8 +: 8] = writedata[b*8 +: 8];
            end
        end
        for (int k = 0; k < 8; k++) vec[k*32 +: 32] = merged[k];
        for (int i = 0; i < 2; i++) begin
            pop   = out_ready && (mcnt[i] > 0);
            push  = write && ((address == 4'd8 && writedata[0]) || (i == 1 && address == 4'd7));
            flush = write && address == 4'd8 && writedata[2];
            if (flush) begin
                mcnt[i] = 0;
            end else begin
                if (pop) begin
                    for (int j = 0; j < 3; j++) mq[i][j] = mq[i][j+1];
                    mcnt[i]--;
                end
                if (push) begin
                    if (mcnt[i] < 4) begin
                        mq[i][mcnt[i]] = vec;
                        mcnt[i]++;
                    end else begin
                        mov[i] = 1'b1;
                    end
                end
            end
            if (write && address == 4'd9 && writedata[18]) mov[i] = 1'b0;
        end
        if (write && address == 4'd8 && writedata[1]) begin
            for (int k = 0; k < 8; k++) msh[k] = '0;
        end else begin
            msh = merged;
        end
    endtask

    task automatic check_outputs();
        chk("valid0", out_valid0, mcnt[0] > 0);
        chk("valid1", out_valid1, mcnt[1] > 0);
        chk("level0", out_level0, mcnt[0]);
        chk("level1", out_level1, mcnt[1]);
        chk("rdata0", readdata0, mrd[0]);
        chk("rdata1", readdata1, mrd[1]);
        if (mcnt[0] > 0) chk("data0", out_data0, mq[0][0]);
        if (mcnt[1] > 0) chk("data1", out_data1, mq[1][0]);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        address = a; read = 1'b1;
        step();
        read = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    logic [255:0] exp_vec;
    int           r;

    initial begin
        rst_n = 1'b0; address = '0; write = 1'b0; writedata = '0;
        byteenable = '0; read = 1'b0; out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_valid0", out_valid0, 1'b0);
        chk("rst_level0", out_level0, 3'd0);
        chk("rst_data0", out_data0, 256'd0);
        chk("rst_rdata0", readdata0, 32'd0);
        chk("rst_data1", out_data1, 256'd0);
        rst_n = 1'b1;
        idle(1);

        // Fill shadow and commit
        for (int k = 0; k < 8; k++) wr(4'(k), 32'h11111111 * (k + 1), 4'hF);
        wr(4'd8, 32'h1, 4'hF);
        for (int k = 0; k < 8; k++) exp_vec[k*32 +: 32] = 32'h11111111 * (k + 1);
        chk("commit_valid", out_valid0, 1'b1);
        chk("commit_data", out_data0, exp_vec);
        chk("commit_level", out_level0, 3'd1);

        // Byte-enable write onto a cleared shadow
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;
        wr(4'd8, 32'h2, 4'hF);
        wr(4'd2, 32'hFFFFFFFF, 4'b0101);
        rd(4'd2);
        chk("be_read", readdata0, 32'h00FF00FF);
        idle(2);
        chk("rd_hold", readdata0, 32'h00FF00FF);

        // Overflow: five commits into a depth-4 FIFO
        for (int c = 0; c < 5; c++) wr(4'd8, 32'h1, 4'hF);
        chk("ovf_level", out_level0, 3'd4);
        rd(4'd9);
        chk("ovf_status", readdata0, 32'h00060004);
        wr(4'd9, 32'h00040000, 4'hF);
        rd(4'd9);
        chk("ovf_clear", readdata0, 32'h00020004);

        // Full with simultaneous pop and push
        wr(4'd3, 32'hCAFEF00D, 4'hF);
        out_ready = 1'b1;
        wr(4'd8, 32'h1, 4'hF);
        chk("fullpp_level", out_level0, 3'd4);
        out_ready = 1'b0;
        rd(4'd9);
        chk("fullpp_noovf", readdata0[18], 1'b0);
        out_ready = 1'b1;
        idle(4);
        chk("drained", out_valid0, 1'b0);
        out_ready = 1'b0;
        wr(4'd9, 32'h00040000, 4'hF);

        // Auto-commit on the last word; COMMIT+CLEAR
        wr(4'd7, 32'h77770000, 4'hF);
        chk("auto_level1", out_level1, 3'd1);
        chk("auto_level0", out_level0, 3'd0);
        wr(4'd8, 32'h3, 4'hF);
        for (int k = 0; k < 8; k++) begin
            rd(4'(k));
            chk("clr_word", readdata0, 32'd0);
        end

        // Flush in the same cycle as a pop
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) wr(4'd8, 32'h1, 4'hF);
        out_ready = 1'b1;
        wr(4'd8, 32'h4, 4'hF);
        chk("flush_level", out_level0, 3'd0);
        chk("flush_valid", out_valid0, 1'b0);
        out_ready = 1'b0;
        rd(4'd9);
        chk("flush_status", readdata0, 32'h00010000);

        // Randomised traffic against the model
        for (int c = 0; c < 400; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                address = 4'($urandom_range(0, 7)); write = 1'b1;
                writedata = $urandom; byteenable = 4'($urandom);
            end else if (r <= 6) begin
                address = 4'd8; write = 1'b1; byteenable = 4'hF;
                writedata = $urandom & 32'h7;
                if ($urandom_range(0, 3) != 0) writedata[2] = 1'b0;
            end else if (r == 7) begin
                address = 4'd9; write = 1'b1; byteenable = 4'hF;
                writedata = $urandom & 32'h00040000;
            end else if (r == 8) begin
                address = 4'($urandom_range(0, 11)); read = 1'b1;
            end
            step();
            write = 1'b0; read = 1'b0;
        end

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        wr(4'd0, 32'h12345678, 4'hF);
        wr(4'd8, 32'h1, 4'hF);
        rd(4'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid0", out_valid0, 1'b0);
        chk("arst_valid1", out_valid1, 1'b0);
        chk("arst_level0", out_level0, 3'd0);
        chk("arst_data0", out_data0, 256'd0);
        chk("arst_data1", out_data1, 256'd0);
        chk("arst_rdata0", readdata0, 32'd0);
        chk("arst_rdata1", readdata1, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(4'd0);
        chk("arst_shadow", readdata0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/avmm_wide_data_fifo.md
Name: avmm_wide_data_fifo

Overview:
- Parametrised successor to the fixed 256-bit fabric data export on the HPS lightweight bridge.
- HPS software writes BUS_W-bit words into a shadow vector, then commits it as one atomic DATA_W-bit entry.
- Committed entries enter a DEPTH-entry FIFO that drains to fabric logic over a valid/ready stream.
- Adds what the fixed export lacks: byte-enable writes, atomic commit, buffering, backpressure, an auto-commit mode, and status/overflow reporting.

Parameters:
- DATA_W, 256, output vector width; must be a multiple of BUS_W.
- BUS_W, 32, Avalon-MM data width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- AUTO_COMMIT, 0, when 1 a write to the highest shadow word also commits.
- Derived: N = DATA_W/BUS_W; AW = clog2(N+2); LW = clog2(DEPTH)+1.

Ports:
- clk_clk in 1: single clock.
- reset_reset_n in 1: asynchronous, active-low reset.
- avs_address in AW: word address.
- avs_write in 1: write strobe.
- avs_writedata in BUS_W: write data.
- avs_byteenable in BUS_W/8: byte lanes for shadow writes.
- avs_read in 1: read strobe.
- avs_readdata out BUS_W: read data, fixed read latency 1.
- out_data out DATA_W: FIFO head.
- out_valid out 1: FIFO non-empty.
- out_ready in 1: consumer accepts the head.
- out_level out LW: FIFO occupancy.

Behaviour:
- Clock and reset: single clock, clk_clk. Reset reset_reset_n is asynchronous, active-low. Reset clears the shadow, all FIFO memory, pointers and the overflow flag.
- Reset values: avs_readdata=0, out_data=0, out_valid=0, out_level=0.
- Register map, words 0..N-1 (SHADOW): word k maps to shadow[k*BUS_W +: BUS_W].
  - Write: applied per byteenable lane.
  - Read: returns the shadow word.
- Register map, word N (CTRL), write-only (reads return 0):
  - bit0 COMMIT.
  - bit1 CLEAR: shadow set to 0.
  - bit2 FLUSH: FIFO emptied, pointers reset.
- Register map, word N+1 (STATUS):
  - Read: [LW-1:0]=level, [16]=empty, [17]=full, [18]=overflow (sticky).
  - Write 1 to bit18 clears overflow.
- Unmapped addresses: writes ignored; reads return 0.
- Read timing: avs_readdata is registered, valid the cycle after avs_read, and holds until the next read.
- No waitrequest: writes complete in the cycle they are presented.
- Commit sources: a CTRL.COMMIT write, or, if AUTO_COMMIT=1, any write to word N-1. With AUTO_COMMIT, the shadow value after the byteenable merge of that write is pushed.
- Commit capture rules:
  - COMMIT pushes the shadow value as it stands before any same-cycle CLEAR.
  - COMMIT and CLEAR in the same write: the old shadow is pushed, then the shadow is zeroed.
- Pop: occurs when out_valid && out_ready. The next entry appears on out_data in the following cycle.
- Push acceptance: a push is accepted if the FIFO is not full, or if a pop occurs in the same cycle (full with pop: level stays DEPTH).
- Push rejection: a push to a full FIFO with no pop is dropped. The FIFO is unchanged and overflow is set to 1.
- FLUSH priority: FLUSH overrides any same-cycle push or pop. Level becomes 0, nothing is pushed, and no overflow is raised.
- Empty FIFO:
  - out_valid=0.
  - out_data holds the last head-slot contents (0 after reset); consumers must ignore it.
  - out_ready is ignored.
- Level arithmetic: level = wr_ptr - rd_ptr, with LW-bit pointers wrapping naturally. full = (level==DEPTH); empty = (level==0).
- Push to pop latency: 1 cycle. An entry pushed in cycle t gives out_valid=1 in cycle t+1.

Decomposition:
- Package avmm_wide_data_pkg holds:
  - CTRL bit indices and STATUS bit indices;
  - a function returning N, and the CTRL/STATUS address offsets.
- One sub-module, sync_fifo_wide (DATA_W, DEPTH). It provides push, pop, flush, full, empty and level, and has the same clock and asynchronous reset.
- The top level holds the address decode, shadow register, commit logic and overflow flag.

Test Plan:
- Reset, then write words 0..7 with 0x11111111 through 0x88888888 and COMMIT (CTRL=0x1). One cycle later: out_valid=1, out_data=0x8888…1111 with word k in bits [32k+31:32k], out_level=1.
- Write word 2 = 0xFFFFFFFF with byteenable=0b0101. Reading word 2 returns 0x00FF00FF (from zero). The readdata is valid exactly 1 cycle after avs_read.
- With out_ready=0, commit 5 times (DEPTH=4). Expect out_level=4, STATUS full=1, overflow=1, and the 5th entry lost. Writing STATUS bit18=1 clears overflow to 0.
- FIFO full, then out_ready=1 and COMMIT in the same cycle. Expect level to stay 4, no overflow, and the new entry at the tail. Draining with out_ready=1 yields the entries in order over 4 cycles.
- AUTO_COMMIT=1: writing word 7 alone pushes 1 entry. CTRL=0x3 (COMMIT+CLEAR) pushes the old shadow, after which words 0..7 read back 0.
- Three entries queued, then CTRL=0x4 FLUSH in the same cycle as a pop. Expect level=0, out_valid=0, no overflow. Assert reset_reset_n low mid-stream: all outputs go to 0 immediately, without waiting for a clock edge.
